// File: rtl/tt_um_logic_unit_pipe.sv
// Two-stage pipelined bitwise gate unit with a chaining accumulator.
// Results leave through a valid/ready stream with zero/ones/parity flags.
module tt_um_logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity,
  output logic [15:0]      out_count
);

  // Handshake: a beat transfers on any rising edge where valid & ready are
  // both high; valid never waits on ready, and a held beat stays stable.
  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NOTB = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XOR  = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] bop;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] s1_y;
  logic             s1_valid;
  logic             in_fire;
  logic             out_fire;
  logic             s2_free;

  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign bop      = in_acc ? acc : in_b;

  always_comb begin
    y = '0;
    unique case (op_e'(in_op))
      OP_AND:  y = in_a & bop;
      OP_OR:   y = in_a | bop;
      OP_NOTA: y = ~in_a;
      OP_NOTB: y = ~bop;
      OP_NAND: y = ~(in_a & bop);
      OP_NOR:  y = ~(in_a | bop);
      OP_XOR:  y = in_a ^ bop;
      OP_XNOR: y = ~(in_a ^ bop);
      default: y = '0;
    endcase
  end

  // Clear wins over the load of the coinciding beat's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (in_fire) begin
      acc <= y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_y     <= y;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 only moves when the consumer side is free, so a stall freezes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_zero   <= 1'b0;
      out_ones   <= 1'b0;
      out_parity <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y      <= s1_y;
        out_zero   <= (s1_y == '0);
        out_ones   <= (s1_y == '1);
        out_parity <= ^s1_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (out_fire) begin
      out_count <= out_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tt_um_logic_unit_pipe.sv
// Directed, table-driven bench for tt_um_logic_unit_pipe (WIDTH=8) with a
// result scoreboard and hand-written stall, latency and reset sequences.
module tb_tt_um_logic_unit_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         acc;
    logic         clr;
    logic [W-1:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         in_acc = 1'b0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         out_ones;
  logic         out_parity;
  logic [15:0]  out_count;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  vec_t vecs[17];
  vec_t bp[4];

  tt_um_logic_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero(out_zero), .out_ones(out_ones),
    .out_parity(out_parity), .out_count(out_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every consumed result is checked against the expected queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(out_y), 32'hFFFF_FFFF);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("out_y", 32'(out_y), 32'(e));
        chk("flags", {29'd0, out_zero, out_ones, out_parity},
            {29'd0, (e == '0), (e == '1), ^e});
      end
    end
  end

  // driver: present one beat, wait (bounded) for acceptance, leave inputs
  // idle right after the accepting edge so calls can run back-to-back
  task automatic send(input vec_t v);
    int n;
    in_a = v.a; in_b = v.b; in_op = v.op; in_acc = v.acc; acc_clr = v.clr;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back(v.y);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{8'h0F, 8'h33, 3'd0, 1'b0, 1'b0, 8'h03};
    vecs[1]  = '{8'h0F, 8'h33, 3'd1, 1'b0, 1'b0, 8'h3F};
    vecs[2]  = '{8'h0F, 8'h33, 3'd2, 1'b0, 1'b0, 8'hF0};
    vecs[3]  = '{8'h0F, 8'h33, 3'd3, 1'b0, 1'b0, 8'hCC};
    vecs[4]  = '{8'h0F, 8'h33, 3'd4, 1'b0, 1'b0, 8'hFC};
    vecs[5]  = '{8'h0F, 8'h33, 3'd5, 1'b0, 1'b0, 8'hC0};
    vecs[6]  = '{8'h0F, 8'h33, 3'd6, 1'b0, 1'b0, 8'h3C};
    vecs[7]  = '{8'h0F, 8'h33, 3'd7, 1'b0, 1'b0, 8'hC3};
    vecs[8]  = '{8'hAA, 8'hAA, 3'd6, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0, 8'hFF};
    vecs[10] = '{8'h01, 8'hFF, 3'd0, 1'b0, 1'b0, 8'h01};
    vecs[11] = '{8'h01, 8'h02, 3'd1, 1'b0, 1'b0, 8'h03};
    vecs[12] = '{8'hFF, 8'h00, 3'd6, 1'b1, 1'b0, 8'hFC};
    vecs[13] = '{8'hF0, 8'h00, 3'd0, 1'b1, 1'b0, 8'hF0};
    vecs[14] = '{8'h5A, 8'h00, 3'd1, 1'b0, 1'b0, 8'h5A};
    vecs[15] = '{8'h00, 8'hFF, 3'd1, 1'b1, 1'b1, 8'h5A};
    vecs[16] = '{8'h00, 8'hFF, 3'd1, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 4; i++)
      bp[i] = '{8'(i + 1), 8'h00, 3'd1, 1'b0, 1'b0, 8'(i + 1)};

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_flags", {29'd0, out_zero, out_ones, out_parity}, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table: truth sweep, flags, accumulator chain, clear, all back-to-back
    for (int i = 0; i < 17; i++) send(vecs[i]);
    drain();
    chk("count_after_table", 32'(out_count), 32'd17);

    // latency: accepted at edge N, visible after N+1
    exp_q.push_back(8'hC3);
    in_a = 8'h0F; in_b = 8'h33; in_op = 3'd7; in_acc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_n1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("latency_n2_valid", 32'(out_valid), 32'd1);
    drain();

    // backpressure: 4-beat stream into a stalled consumer
    begin
      int idx;
      int cyc;
      logic took;
      out_ready = 1'b0;
      idx = 0;
      for (cyc = 0; cyc < 6; cyc++) begin
        in_a = bp[idx].a; in_b = bp[idx].b; in_op = bp[idx].op; in_acc = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        took = in_ready;
        if (took) exp_q.push_back(bp[idx].y);
        if (cyc >= 3) chk("stall_out_y", 32'(out_y), 32'h01);
        @(posedge clk); #1;
        if (took) idx++;
      end
      chk("stall_accepted", 32'(idx), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      cyc = 0;
      while (idx < 4 && cyc < 20) begin
        in_a = bp[idx].a; in_b = bp[idx].b; in_op = bp[idx].op;
        in_valid = 1'b1;
        @(negedge clk);
        took = in_ready;
        if (took) exp_q.push_back(bp[idx].y);
        @(posedge clk); #1;
        if (took) idx++;
        cyc++;
      end
      in_valid = 1'b0;
      chk("bp_all_accepted", 32'(idx), 32'd4);
      drain();
    end
    chk("count_after_bp", 32'(out_count), 32'd22);

    // async reset with two beats in flight
    out_ready = 1'b0;
    send(bp[0]);
    send(bp[1]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(out_count), 32'd0);
    chk("midrst_acc", 32'(dut.acc), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send('{8'hFF, 8'hFF, 3'd0, 1'b1, 1'b0, 8'h00});
    drain();
    chk("count_after_rst", 32'(out_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
